// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame scheduler.
// Frame framing constants and FSM state encoding.
package uart_pkg;

    localparam int FRAME_LEN_DEF = 20;

    localparam logic [2:0] HDR_TAG = 3'b101;
    localparam logic [7:0] IDLE_ID = 8'hFF;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARB  = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        ARB  = ST_ARB,
        REQ  = ST_REQ,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last served source.
// Pointer only advances when a granted frame actually completes.
module rr_arbiter #(
    parameter int NSRC = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NSRC-1:0]         req,
    input  logic                    load,
    input  logic [$clog2(NSRC)-1:0] load_idx,
    output logic [$clog2(NSRC)-1:0] grant,
    output logic                    valid
);

    localparam int IW = $clog2(NSRC);

    logic [IW-1:0] last;
    logic [IW-1:0] idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= IW'(NSRC - 1);
        end else if (load) begin
            last <= load_idx;
        end
    end

    // Walk offsets high to low so the nearest requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = |req;
        for (int i = NSRC; i >= 1; i--) begin
            idx = IW'((int'(last) + i) % NSRC);
            if (req[idx]) grant = idx;
        end
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Frame scheduler for the RS-485 UART transmitter: slot timing,
// source arbitration, and header/id/payload/checksum byte serving.
module uart_frame_scheduler
    import uart_pkg::*;
#(
    parameter int          NSRC      = 4,
    parameter int          FRAME_LEN = FRAME_LEN_DEF,
    parameter logic [15:0] PERIOD    = 16'd48000,
    parameter logic [4:0]  CYCLES    = 5'd20,
    parameter logic [15:0] TIMEOUT   = 16'd1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [NSRC-1:0]   src_req,
    output logic [NSRC-1:0]   src_ack,
    output logic [4:0]        src_addr,
    input  logic [8*NSRC-1:0] src_data,
    input  logic [4:0]        tx_addr,
    input  logic              tx_dir,
    output logic              rq,
    output logic [7:0]        tx_data,
    output logic [4:0]        cycle,
    output logic              busy,
    output logic              timeout_err,
    output logic              overrun_err,
    input  logic              err_clr
);

    localparam int IW = $clog2(NSRC);
    localparam logic [4:0] LAST  = 5'(FRAME_LEN - 1);
    localparam logic [4:0] PLAST = 5'(FRAME_LEN - 2);

    state_t        state, state_nx;
    logic [15:0]   slot_cnt;
    logic          slot;
    logic [15:0]   tmo_cnt;
    logic          tmo_hit;
    logic          tx_dir_q;
    logic          dir_fall;
    logic [IW-1:0] arb_grant, grant_q;
    logic          arb_valid, valid_q;
    logic          done_ok;
    logic [4:0]    addr_q;
    logic [7:0]    csum, csum_nx, byte_nx, payload;
    logic          in_pay;

    rr_arbiter #(.NSRC(NSRC)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (src_req),
        .load     (done_ok),
        .load_idx (grant_q),
        .grant    (arb_grant),
        .valid    (arb_valid)
    );

    assign slot     = en && (slot_cnt == PERIOD - 16'd1);
    assign dir_fall = tx_dir_q && !tx_dir;
    assign tmo_hit  = (state == REQ) && !tx_dir
                   && (tmo_cnt == TIMEOUT - 16'd1);
    assign done_ok  = (state == DONE) && valid_q;
    assign rq       = (state == REQ);
    assign busy     = (state != IDLE);
    assign src_ack  = done_ok ? ({{(NSRC-1){1'b0}}, 1'b1} << grant_q)
                              : '0;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (slot) state_nx = ARB;
            ARB:  state_nx = REQ;
            REQ: begin
                if (tx_dir)       state_nx = RUN;
                else if (tmo_hit) state_nx = IDLE;
            end
            RUN:  if (dir_fall) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            slot_cnt    <= '0;
            tmo_cnt     <= '0;
            tx_dir_q    <= 1'b0;
            grant_q     <= '0;
            valid_q     <= 1'b0;
            cycle       <= '0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state    <= state_nx;
            tx_dir_q <= tx_dir;
            slot_cnt <= (!en || slot) ? 16'd0 : slot_cnt + 16'd1;
            if (state == ARB) begin
                tmo_cnt <= '0;
                grant_q <= arb_grant;
                valid_q <= arb_valid;
            end else if (state == REQ) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (state == DONE)
                cycle <= (cycle == CYCLES - 5'd1) ? 5'd0 : cycle + 5'd1;
            if (tmo_hit)      timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
            if (slot && state != IDLE) overrun_err <= 1'b1;
            else if (err_clr)          overrun_err <= 1'b0;
        end
    end

    assign in_pay   = (tx_addr >= 5'd2) && (tx_addr <= PLAST);
    assign src_addr = in_pay ? tx_addr - 5'd2 : 5'd0;
    assign payload  = valid_q ? src_data[{grant_q, 3'b000} +: 8] : 8'h00;

    // tx_data still holds the byte being left, so fold it in here; the
    // checksum address then sees the last payload byte without a lag.
    assign csum_nx = (tx_addr != addr_q && addr_q <= PLAST)
                   ? csum ^ tx_data : csum;

    always_comb begin
        byte_nx = 8'hFF;
        unique case (1'b1)
            (tx_addr == 5'd0): byte_nx = {HDR_TAG, cycle};
            (tx_addr == 5'd1):
                byte_nx = valid_q ? {{(8-IW){1'b0}}, grant_q} : IDLE_ID;
            in_pay:            byte_nx = payload;
            (tx_addr == LAST): byte_nx = csum_nx;
            default:           byte_nx = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            csum    <= '0;
            tx_data <= 8'hFF;
        end else begin
            addr_q  <= tx_addr;
            csum    <= (state == ARB) ? 8'h00 : csum_nx;
            tx_data <= byte_nx;
        end
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler: emulates the UART TX side
// and compares every served byte against a frame model.
module tb_uart_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  src_req;
    logic [3:0]  src_ack;
    logic [4:0]  src_addr;
    logic [31:0] src_data;
    logic [4:0]  tx_addr;
    logic        tx_dir;
    logic        rq;
    logic [7:0]  tx_data;
    logic [4:0]  cycle;
    logic        busy;
    logic        timeout_err;
    logic        overrun_err;
    logic        err_clr;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int rise_t = 0;
    logic [4:0] mcyc = 5'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    uart_frame_scheduler #(
        .NSRC(4), .FRAME_LEN(20), .PERIOD(16'd200),
        .CYCLES(5'd20), .TIMEOUT(16'd50)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .src_req(src_req), .src_ack(src_ack),
        .src_addr(src_addr), .src_data(src_data),
        .tx_addr(tx_addr), .tx_dir(tx_dir), .rq(rq),
        .tx_data(tx_data), .cycle(cycle), .busy(busy),
        .timeout_err(timeout_err), .overrun_err(overrun_err),
        .err_clr(err_clr)
    );

    function automatic logic [7:0] src_byte(input int k, input logic [4:0] a);
        case (k)
            0:       return 8'hC0 ^ {3'b000, a};
            1:       return {3'b000, a} + 8'h30;
            2:       return {3'b000, a} + 8'h01;
            default: return 8'h80 | {3'b000, a};
        endcase
    endfunction

    assign src_data = {src_byte(3, src_addr), src_byte(2, src_addr),
                       src_byte(1, src_addr), src_byte(0, src_addr)};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rq();
        int n = 0;
        while (!rq && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rq_seen", {31'b0, rq}, 32'd1);
        rise_t = cyc_cnt;
    endtask

    task automatic run_frame(input bit v, input int g);
        logic [7:0] exp [20];
        logic [7:0] x;
        exp[0] = {3'b101, mcyc};
        exp[1] = v ? 8'(g) : 8'hFF;
        for (int i = 2; i <= 18; i++)
            exp[i] = v ? src_byte(g, 5'(i - 2)) : 8'h00;
        x = 8'h00;
        for (int i = 0; i <= 18; i++) x ^= exp[i];
        exp[19] = x;
        wait_rq();
        tx_dir = 1'b1;
        @(negedge clk);
        check("rq_drop", {31'b0, rq}, 32'd0);
        check("busy_run", {31'b0, busy}, 32'd1);
        for (int a = 0; a < 20; a++) begin
            tx_addr = 5'(a);
            @(negedge clk);
            @(negedge clk);
            check($sformatf("c%0d_byte%0d", mcyc, a), {24'b0, tx_data},
                  {24'b0, exp[a]});
        end
        tx_addr = 5'd20;
        @(negedge clk);
        @(negedge clk);
        check("beyond", {24'b0, tx_data}, 32'hFF);
        tx_addr = 5'd0;
        tx_dir = 1'b0;
        @(negedge clk);
        check("ack", {28'b0, src_ack}, v ? (32'd1 << g) : 32'd0);
        @(negedge clk);
        check("ack_clr", {28'b0, src_ack}, 32'd0);
        check("idle", {31'b0, busy}, 32'd0);
        mcyc = (mcyc == 5'd19) ? 5'd0 : mcyc + 5'd1;
        check("cycle", {27'b0, cycle}, {27'b0, mcyc});
    endtask

    initial begin
        int n;
        int t0;
        reset = 1'b0;
        en = 1'b0;
        src_req = 4'b0;
        tx_addr = 5'd0;
        tx_dir = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rq", {31'b0, rq}, 32'd0);
        check("rst_ack", {28'b0, src_ack}, 32'd0);
        check("rst_txd", {24'b0, tx_data}, 32'hFF);
        check("rst_cyc", {27'b0, cycle}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {30'b0, timeout_err, overrun_err}, 32'd0);
        reset = 1'b1;
        en = 1'b1;

        run_frame(0, 0);
        t0 = rise_t;
        run_frame(0, 0);
        check("period", rise_t - t0, 32'd200);

        src_req = 4'b1010;
        run_frame(1, 1);
        run_frame(1, 3);
        run_frame(1, 1);
        run_frame(1, 3);

        src_req = 4'b0100;
        run_frame(1, 2);
        src_req = 4'b0000;

        for (int i = 0; i < 14; i++) run_frame(0, 0);
        check("wrapped", {27'b0, mcyc}, 32'd1);

        wait_rq();
        n = 0;
        while (rq && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("tmo_len", n, 32'd50);
        check("tmo_err", {31'b0, timeout_err}, 32'd1);
        check("tmo_idle", {31'b0, busy}, 32'd0);
        check("tmo_cyc", {27'b0, cycle}, {27'b0, mcyc});
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("tmo_clr", {31'b0, timeout_err}, 32'd0);

        err_clr = 1'b1;
        wait_rq();
        n = 0;
        while (rq && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("set_wins", {31'b0, timeout_err}, 32'd1);
        @(negedge clk);
        check("clr_after", {31'b0, timeout_err}, 32'd0);
        err_clr = 1'b0;

        wait_rq();
        tx_dir = 1'b1;
        repeat (250) @(negedge clk);
        check("ovr_err", {31'b0, overrun_err}, 32'd1);
        check("ovr_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("arst_rq", {31'b0, rq}, 32'd0);
        check("arst_cyc", {27'b0, cycle}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_ovr", {31'b0, overrun_err}, 32'd0);
        check("arst_txd", {24'b0, tx_data}, 32'hFF);
        @(negedge clk);
        tx_dir = 1'b0;
        reset = 1'b1;

        wait_rq();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_req_rq", {31'b0, rq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_scheduler.md
Name: uart_frame_scheduler

Overview:
- Sequences the RS-485 UART transmitter.
- Issues periodic frame requests (RQ) and drives the cycle counter.
- Round-robin arbitrates NSRC payload sources into frame slots and serves the TX byte stream by address.
- Assembles each frame as header, source id, payload and XOR checksum.
- Sits between the telemetry sources and the UART TX block, in the TX clock domain.

Parameters:
- NSRC, 4: number of payload sources; grant index is 2 bits wide.
- FRAME_LEN, 20: bytes per frame. Must match the TX wrap count.
- PERIOD, 16'd48000: clocks between frame slots.
- CYCLES, 5'd20: cycle counter modulus.
- TIMEOUT, 16'd1000: maximum clocks from RQ rise to the TX direction-line rise.

Ports:
- clk  in  1  TX clock.
- reset  in  1  asynchronous, active-low; low = reset.
- en  in  1  scheduling enable.
- src_req  in  NSRC  source has a payload pending (level).
- src_ack  out  NSRC  one-clock pulse when that source's frame completes.
- src_addr  out  5  payload byte index, 0..FRAME_LEN-4.
- src_data  in  8*NSRC  payload byte per source; byte i at [8i+7:8i]; combinational on src_addr.
- tx_addr  in  5  byte address from the TX.
- tx_dir  in  1  TX receive-direction line (dirRX); high = frame in progress.
- rq  out  1  transfer request to the TX.
- tx_data  out  8  byte for tx_addr (registered).
- cycle  out  5  frame cycle number.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky.
- overrun_err  out  1  sticky.
- err_clr  in  1  clears both sticky flags.

Behaviour:
- Reset values: rq=0, src_ack=0, tx_data=8'hFF, cycle=0, busy=0, both error flags=0, state=IDLE, slot counter=0.
- Slot counter: counts 0..PERIOD-1 while en=1. Holds at 0 while en=0. Reaching PERIOD-1 raises a one-clock slot pulse.
- FSM states: IDLE, ARB, REQ, RUN, DONE.
- IDLE: on slot go to ARB.
- Slot while not in IDLE: the slot is dropped and overrun_err sets.
- ARB (1 clock): round-robin grant. Search starts at last_grant+1 and wraps. Latch grant and valid=|src_req.
  - No request pending: idle frame with id 8'hFF and payload 8'h00.
  - Reset value of last_grant = NSRC-1, so the first grant is source 0.
  - Clear checksum. Go to REQ.
- REQ: rq=1. Leave on tx_dir=1: go to RUN and set rq=0.
  - Timeout: count reaches TIMEOUT without tx_dir=1 → rq=0, set timeout_err, go to IDLE. No ack, cycle unchanged.
- RUN: wait for tx_dir falling edge → DONE.
- DONE (1 clock):
  - src_ack[grant] pulses if valid; last_grant updates only if valid.
  - cycle wraps CYCLES-1 → 0, otherwise increments.
  - Go to IDLE.
- Frame bytes by tx_addr:
  - 0: {3'b101, cycle}.
  - 1: {6'b0, grant}, or 8'hFF for an idle frame.
  - 2..FRAME_LEN-2: payload from the granted source at src_addr = tx_addr-2.
  - FRAME_LEN-1: XOR of bytes 0..FRAME_LEN-2.
  - tx_addr ≥ FRAME_LEN: 8'hFF.
- tx_data latency: valid 1 clock after any tx_addr change. The TX needs ≥2.
- Checksum:
  - Accumulates each byte once, on the tx_addr change leaving it.
  - The last-byte value must include byte FRAME_LEN-2 even though that byte and the checksum address are consecutive.
- Sources must hold payload stable from grant until src_ack.
- src_req deasserting mid-frame does not alter the frame.
- en falling mid-frame: the current frame completes; no new slots.
- err_clr and a set event in the same clock: set wins.
- reset low mid-frame: everything returns to reset values at once; rq drops.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams;
  - HDR_TAG=3'b101 and IDLE_ID=8'hFF;
  - FRAME_LEN default.
- One natural sub-module: rr_arbiter (NSRC requests, last-grant pointer, grant index and valid). Pure combinational plus pointer update enable.

Test Plan:
- Idle frames: en=1, src_req=0, PERIOD=200 → rq every 200 clocks. Bytes = A0,FF,00×17,checksum 5F. Then A1,FF… and cycle=1.
- Arbitration: src_req=4'b1010 held → grants 1,3,1,3. src_ack[1] and src_ack[3] pulse once per frame, each 1 clock after tx_dir falls.
- Payload and checksum: source 2 data = src_addr+1 → bytes 2..18 = 01..11. Byte 19 = XOR of all prior bytes, checked against the model.
- Cycle wrap: run CYCLES+1 frames → header low bits go 0..19 then 0. The frame after wrap header = A0.
- Timeout: tx_dir tied low → rq high exactly TIMEOUT clocks, then 0. timeout_err=1; err_clr clears it.
- Overrun and reset: PERIOD shorter than the frame → overrun_err=1. Assert reset during RUN → rq=0, cycle=0, busy=0 the same clock.
